xor_share_sched: RTL and testbench

Round-robin scheduler that shares one bit-serial XOR cell, built from four two-input NANDs, among `NREQ` requesters. Each requester submits a pair of `W`-bit operands. The block grants one requester at a time and streams the operands LSB-first through the single XOR cell, one bit per cycle. It returns the `W`-bit result tagged with the requester index over a valid/ready response port. It sits between the lab datapath's gate-level XOR cell and any number of clients that need word-wide XOR without replicating the cell.

---
 rtl/xor_share_sched.sv | 137 +++++++++++++
 tb/tb_xor_share_sched.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_share_sched.sv
// Round-robin scheduler sharing one bit-serial, NAND-built XOR cell among NREQ requesters.
// Latency: grant on edge G, rsp_valid after edge G+W; earliest next grant one edge after the rsp handshake.
// Backpressure: rsp_ready low holds DONE with rsp_y/rsp_id stable; req_ready stays low outside IDLE.

module xor_share_nand2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

// Classic four-NAND XOR: the only place result bits are produced.
module xor_share_cell (
    input  logic a,
    input  logic b,
    output logic x
);
    logic n1, n2, n3;

    xor_share_nand2 u_n1 (.a(a),  .b(b),  .y(n1));
    xor_share_nand2 u_n2 (.a(a),  .b(n1), .y(n2));
    xor_share_nand2 u_n3 (.a(b),  .b(n1), .y(n3));
    xor_share_nand2 u_n4 (.a(n2), .b(n3), .y(x));
endmodule

module xor_share_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_y,
    output logic              busy
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic           any_vld;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   sa;
    logic [W-1:0]   sb;
    logic [W-1:0]   res;
    logic           x;

    // Round-robin pick: first valid requester scanning upward from ptr, wrapping at NREQ.
    always_comb begin
        winner  = '0;
        cand    = '0;
        any_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!any_vld && req_valid[cand]) begin
                any_vld = 1'b1;
                winner  = cand;
            end
        end
    end

    // Grant is one-hot on the winner, only in IDLE and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == ST_IDLE) && any_vld) begin
            req_ready[winner] = 1'b1;
        end
    end

    xor_share_cell u_cell (
        .a (sa[0]),
        .b (sb[0]),
        .x (x)
    );

    // FSM plus datapath: load on grant, shift one bit per cycle, hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= '0;
            id    <= '0;
            cnt   <= '0;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_vld) begin
                        sa    <= req_a[int'(winner)*W +: W];
                        sb    <= req_b[int'(winner)*W +: W];
                        id    <= winner;
                        cnt   <= '0;
                        ptr   <= (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // New bit enters at the MSB so the first processed bit ends up at bit 0.
                    res <= (res >> 1) | (W'(x) << (W-1));
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W-1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign rsp_y     = res;
    assign rsp_id    = id;

endmodule

// File: tb/tb_xor_share_sched.sv
module tb_xor_share_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_y;
    logic        busy;

    logic [1:0]  v1;
    logic [1:0]  a1;
    logic [1:0]  b1;
    logic [1:0]  rdy1;
    logic        rv1;
    logic        rr1;
    logic [0:0]  id1;
    logic [0:0]  y1;
    logic        busy1;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;
    int mptr     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    xor_share_sched #(.NREQ(4), .W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy)
    );

    xor_share_sched #(.NREQ(2), .W(1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_a(a1), .req_b(b1),
        .req_ready(rdy1), .rsp_valid(rv1), .rsp_ready(rr1),
        .rsp_id(id1), .rsp_y(y1), .busy(busy1)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference arbitration: first pending index at or after p, modulo 4.
    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Poll for a grant; 'at' is the cycle it was seen, -1 on timeout.
    task automatic wait_grant(output logic [3:0] g, output int at);
        g  = '0;
        at = -1;
        for (int t = 0; t < 200; t++) begin
            #1;
            if (req_ready != 4'b0) begin
                g  = req_ready;
                at = cyc_cnt;
                return;
            end
            @(posedge clk);
        end
    endtask

    // Observe one operation starting just after its grant edge; lat=-1 on timeout.
    task automatic collect(input bit bp, output int lat, output int nb,
                           output logic [7:0] y, output logic [1:0] id);
        lat = -1;
        nb  = 0;
        y   = 'x;
        id  = 'x;
        for (int t = 0; t < 200; t++) begin
            if (busy) nb++;
            if (rsp_valid && lat < 0) begin
                lat = t;
                y   = rsp_y;
                id  = rsp_id;
            end
            if (!busy && t > 0) return;
            rsp_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        v1 = '0; a1 = '0; b1 = '0; rr1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        checks++; if (rsp_y !== 8'h00) begin failures++; $display("FAIL reset_rsp_y got=%h exp=00", rsp_y); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rv1 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL reset_w1 got=%b%b exp=00", rv1, busy1); end
        mptr = 0;
    endtask

    task automatic test_all_four();
        logic [3:0] g, pend;
        logic [7:0] y;
        logic [1:0] id;
        int at, prev, w, lat, nb;
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = 8'(i);
            req_b[i*8 +: 8] = 8'hF0;
        end
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL ready_in_reset got=%b exp=0000", req_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        pend = 4'hF;
        prev = -1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(g, at);
            w = rr_pick(pend, mptr);
            checks++; if (g !== (4'b0001 << w)) begin failures++; $display("FAIL all4_grant got=%b exp=%b", g, 4'b0001 << w); end
            if (k > 0) begin
                checks++; if (at - prev != 10) begin failures++; $display("FAIL all4_spacing got=%0d exp=10", at - prev); end
            end
            prev = at;
            tick();
            pend[w] = 1'b0; req_valid = pend; mptr = (w + 1) % 4;
            collect(1'b0, lat, nb, y, id);
            checks++; if (y !== (8'(w) ^ 8'hF0) || id !== 2'(w)) begin
                failures++; $display("FAIL all4_result got=%h/%0d exp=%h/%0d", y, id, 8'(w) ^ 8'hF0, w);
            end
        end
    endtask

    task automatic test_fairness();
        logic [3:0] g;
        logic [7:0] y, ea[4], eb[4];
        logic [1:0] id;
        int at, w, lat, nb;
        for (int i = 0; i < 4; i++) begin
            ea[i] = 8'($urandom); eb[i] = 8'($urandom);
            req_a[i*8 +: 8] = ea[i]; req_b[i*8 +: 8] = eb[i];
        end
        req_valid = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            wait_grant(g, at);
            w = rr_pick(4'b0101, mptr);
            checks++; if (g !== (4'b0001 << w)) begin failures++; $display("FAIL fair_grant got=%b exp=%b", g, 4'b0001 << w); end
            tick();
            mptr = (w + 1) % 4;
            collect(1'b0, lat, nb, y, id);
            if (k == 3) req_valid = '0;
            checks++; if (y !== (ea[w] ^ eb[w]) || id !== 2'(w)) begin
                failures++; $display("FAIL fair_result got=%h/%0d exp=%h/%0d", y, id, ea[w] ^ eb[w], w);
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] g;
        logic [7:0] y;
        logic [1:0] id;
        int at, lat, nb;
        req_a[15:8] = 8'hA5; req_b[15:8] = 8'h0F;
        req_valid = 4'b0010; rsp_ready = 1'b1;
        wait_grant(g, at);
        checks++; if (g !== 4'b0010) begin failures++; $display("FAIL single_grant got=%b exp=0010", g); end
        tick();
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL single_ready_drop got=%b exp=0000", req_ready); end
        req_valid = '0; mptr = 2;
        collect(1'b0, lat, nb, y, id);
        checks++; if (lat != 8) begin failures++; $display("FAIL single_latency got=%0d exp=8", lat); end
        checks++; if (y !== 8'hAA || id !== 2'd1) begin failures++; $display("FAIL single_result got=%h/%0d exp=aa/1", y, id); end
        checks++; if (nb != 9) begin failures++; $display("FAIL single_busy got=%0d exp=9", nb); end
    endtask

    task automatic test_backpressure();
        logic [3:0] g;
        logic [7:0] y, a0, b0, a3, b3;
        logic [1:0] id;
        int at, w, lat, nb;
        a0 = 8'($urandom); b0 = 8'($urandom); a3 = 8'($urandom); b3 = 8'($urandom);
        req_a[7:0] = a0; req_b[7:0] = b0;
        req_valid = 4'b0001; rsp_ready = 1'b0;
        wait_grant(g, at);
        w = rr_pick(4'b0001, mptr);
        checks++; if (g !== (4'b0001 << w)) begin failures++; $display("FAIL bp_grant got=%b exp=%b", g, 4'b0001 << w); end
        tick();
        mptr = (w + 1) % 4;
        req_a[31:24] = a3; req_b[31:24] = b3; req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL bp_no_grant_shift got=%b exp=0000", req_ready); end
        for (int t = 0; t < 50; t++) begin
            if (rsp_valid) break;
            tick();
        end
        checks++; if (rsp_valid !== 1'b1 || rsp_y !== (a0 ^ b0) || rsp_id !== 2'd0) begin
            failures++; $display("FAIL bp_first_rsp got=%b/%h/%0d exp=1/%h/0", rsp_valid, rsp_y, rsp_id, a0 ^ b0);
        end
        for (int t = 0; t < 5; t++) begin
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_y !== (a0 ^ b0) || rsp_id !== 2'd0 || req_ready !== 4'b0) begin
                failures++; $display("FAIL bp_hold got=%b/%h/%0d/%b exp=1/%h/0/0000", rsp_valid, rsp_y, rsp_id, req_ready, a0 ^ b0);
            end
        end
        rsp_ready = 1'b1;
        tick();
        checks++; if (req_ready !== 4'b1000 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL bp_grant_after got=%b/%b exp=1000/0", req_ready, rsp_valid);
        end
        tick();
        req_valid = '0; mptr = 0;
        collect(1'b0, lat, nb, y, id);
        checks++; if (lat != 8 || y !== (a3 ^ b3) || id !== 2'd3) begin
            failures++; $display("FAIL bp_second_rsp got=%0d/%h/%0d exp=8/%h/3", lat, y, id, a3 ^ b3);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] g;
        logic [7:0] y, a0, b0, a3, b3;
        logic [1:0] id;
        int at, w, lat, nb;
        bit saw;
        req_a[23:16] = 8'hFF; req_b[23:16] = 8'h00;
        req_valid = 4'b0100; rsp_ready = 1'b1;
        wait_grant(g, at);
        w = rr_pick(4'b0100, mptr);
        checks++; if (g !== (4'b0001 << w)) begin failures++; $display("FAIL rmid_grant got=%b exp=%b", g, 4'b0001 << w); end
        tick();
        req_valid = '0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_ctrl got=%b/%b exp=0/0", busy, rsp_valid); end
        checks++; if (rsp_y !== 8'h00 || rsp_id !== 2'd0 || req_ready !== 4'b0) begin
            failures++; $display("FAIL rmid_data got=%h/%0d/%b exp=00/0/0000", rsp_y, rsp_id, req_ready);
        end
        mptr = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (12) begin
            tick();
            if (rsp_valid) saw = 1'b1;
        end
        checks++; if (saw) begin failures++; $display("FAIL rmid_ghost_rsp got=1 exp=0"); end
        a0 = 8'($urandom); b0 = 8'($urandom); a3 = 8'($urandom); b3 = 8'($urandom);
        req_a[7:0] = a0; req_b[7:0] = b0; req_a[31:24] = a3; req_b[31:24] = b3;
        req_valid = 4'b1001;
        wait_grant(g, at);
        w = rr_pick(4'b1001, mptr);
        checks++; if (g !== (4'b0001 << w)) begin failures++; $display("FAIL rmid_first got=%b exp=%b", g, 4'b0001 << w); end
        tick();
        req_valid = 4'b1000; mptr = (w + 1) % 4;
        collect(1'b0, lat, nb, y, id);
        checks++; if (y !== (a0 ^ b0) || id !== 2'd0) begin failures++; $display("FAIL rmid_rsp0 got=%h/%0d exp=%h/0", y, id, a0 ^ b0); end
        wait_grant(g, at);
        w = rr_pick(4'b1000, mptr);
        checks++; if (g !== (4'b0001 << w)) begin failures++; $display("FAIL rmid_wrap got=%b exp=%b", g, 4'b0001 << w); end
        tick();
        req_valid = '0; mptr = (w + 1) % 4;
        collect(1'b0, lat, nb, y, id);
        checks++; if (y !== (a3 ^ b3) || id !== 2'd3) begin failures++; $display("FAIL rmid_rsp3 got=%h/%0d exp=%h/3", y, id, a3 ^ b3); end
    endtask

    task automatic test_boundary();
        logic [3:0] g;
        logic [7:0] y, ta[2], tb[2];
        logic [1:0] id;
        logic ea, eb;
        int at, w, lat, nb;
        ta[0] = 8'hFF; tb[0] = 8'hFF; ta[1] = 8'hFF; tb[1] = 8'h00;
        for (int k = 0; k < 2; k++) begin
            req_a[15:8] = ta[k]; req_b[15:8] = tb[k]; req_valid = 4'b0010;
            wait_grant(g, at);
            w = rr_pick(4'b0010, mptr);
            tick();
            req_valid = '0; mptr = (w + 1) % 4;
            collect(1'b0, lat, nb, y, id);
            checks++; if (g !== 4'b0010 || lat != 8 || y !== (ta[k] ^ tb[k])) begin
                failures++; $display("FAIL bound_w8 got=%b/%0d/%h exp=0010/8/%h", g, lat, y, ta[k] ^ tb[k]);
            end
        end
        // W=1 instance: requester 0 then requester 1.
        for (int k = 0; k < 2; k++) begin
            ea = 1'b1; eb = (k == 1);
            a1[k] = ea; b1[k] = eb; v1 = 2'b01 << k; rr1 = 1'b1;
            #1;
            checks++; if (rdy1 !== (2'b01 << k)) begin failures++; $display("FAIL w1_grant got=%b exp=%b", rdy1, 2'b01 << k); end
            tick();
            v1 = '0;
            checks++; if (busy1 !== 1'b1 || rv1 !== 1'b0) begin failures++; $display("FAIL w1_shift got=%b/%b exp=1/0", busy1, rv1); end
            tick();
            checks++; if (rv1 !== 1'b1 || y1 !== (ea ^ eb) || id1 !== 1'(k)) begin
                failures++; $display("FAIL w1_rsp got=%b/%b/%0d exp=1/%b/%0d", rv1, y1, id1, ea ^ eb, k);
            end
            tick();
            checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL w1_idle got=%b exp=0", busy1); end
        end
    endtask

    task automatic test_random();
        logic [3:0] g, pend;
        logic [7:0] y, ea[4], eb[4];
        logic [1:0] id;
        int at, w, lat, nb, r;
        pend = '0;
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    ea[i] = 8'($urandom); eb[i] = 8'($urandom);
                    req_a[i*8 +: 8] = ea[i]; req_b[i*8 +: 8] = eb[i];
                end
            end
            if (pend == 4'b0) begin
                r = $urandom_range(0, 3);
                pend[r] = 1'b1;
                ea[r] = 8'($urandom); eb[r] = 8'($urandom);
                req_a[r*8 +: 8] = ea[r]; req_b[r*8 +: 8] = eb[r];
            end
            req_valid = pend;
            wait_grant(g, at);
            w = rr_pick(pend, mptr);
            checks++; if (g !== (4'b0001 << w)) begin failures++; $display("FAIL rand_grant got=%b exp=%b", g, 4'b0001 << w); end
            tick();
            pend[w] = 1'b0; req_valid = pend; mptr = (w + 1) % 4;
            collect(1'b1, lat, nb, y, id);
            checks++; if (lat != 8 || y !== (ea[w] ^ eb[w]) || id !== 2'(w)) begin
                failures++; $display("FAIL rand_rsp got=%0d/%h/%0d exp=8/%h/%0d", lat, y, id, ea[w] ^ eb[w], w);
            end
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_all_four();
        test_fairness();
        test_single();
        test_backpressure();
        test_reset_mid();
        test_boundary();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
